rr_priority_arbiter_8: RTL

- Eight-requester arbiter that shares a single downstream resource. It uses the team's 8-to-3 priority encoding (highest index wins, valid flag) as its selection core.
- Adds sequencing on top of the encoder: grant hold, release handshake, timeout, and optional rotating (round-robin) priority.
- Sits between requesting engines and a shared port; the granted index drives the resource mux select.

---
 rtl/rr_priority_arbiter_8.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rr_priority_arbiter_8.sv
// Eight-requester arbiter: priority-encoded selection (fixed or rotating) with
// grant hold, done/withdraw release, forced release after MAX_HOLD cycles.
module rr_priority_arbiter_8 #(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned HOLD_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] out,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [7:0]          gnt_q, gnt_d;
    logic [2:0]          out_q, out_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          ptr_q, ptr_d;

    logic                win_found;
    logic [2:0]          win_idx;
    logic [2:0]          cand;

    // Winner select: descending from ptr with wrap, or highest index when fixed
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        if (ROUND_ROBIN != 0) begin
            for (int i = 0; i < 8; i++) begin
                cand = ptr_q - 3'(i);
                if (!win_found && req[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d   = 8'd0;
                out_d   = 3'd0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win_idx;
                    out_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = HOLD_W'(1);
                    if (ROUND_ROBIN != 0) begin
                        ptr_d = win_idx - 3'd1;
                    end
                end
            end
            GRANT: begin
                // done outranks withdrawal, which outranks the hold limit
                if (done || !req[out_q] || (cnt_q == HOLD_W'(MAX_HOLD))) begin
                    state_d   = IDLE;
                    gnt_d     = 8'd0;
                    out_d     = 3'd0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    timeout_d = !done && req[out_q];
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 8'd0;
            out_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= 3'd7;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign out     = out_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule
